// File: rtl/axi4_lite_slave.sv
// AXI4-Lite register bank responder: B/R valid one cycle after the last address/data handshake.
// Responses hold until BREADY/RREADY, and no new AW/W is accepted while a write response is pending.
`timescale 1ns/1ps
module axi4_lite_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           iCLK,
    input  logic                           iRST,
    input  logic                           s_AWVALID,
    output logic                           s_AWREADY,
    input  logic [ADDR_WIDTH-1:0]          s_AWADDR,
    input  logic [2:0]                     s_AWPROT,
    input  logic                           s_WVALID,
    output logic                           s_WREADY,
    input  logic [DATA_WIDTH-1:0]          s_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        s_WSTRB,
    output logic                           s_BVALID,
    input  logic                           s_BREADY,
    output logic [1:0]                     s_BRESP,
    input  logic                           s_ARVALID,
    output logic                           s_ARREADY,
    input  logic [ADDR_WIDTH-1:0]          s_ARADDR,
    input  logic [2:0]                     s_ARPROT,
    output logic                           s_RVALID,
    input  logic                           s_RREADY,
    output logic [DATA_WIDTH-1:0]          s_RDATA,
    output logic [1:0]                     s_RRESP,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RESP = 1'b1;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  aw_held_q, w_held_q, bvalid_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [NUM_REGS-1:0]   pulse_q;
    logic [0:0]            rstate_q, rstate_d;

    logic                  aw_hs, w_hs, ar_hs, commit, wr_in_range, rd_in_range;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  unused_prot;

    assign unused_prot = ^{s_AWPROT, s_ARPROT};

    // Readiness is gated by the reset input itself so nothing handshakes while iRST is low.
    assign s_AWREADY = iRST && !aw_held_q && !bvalid_q;
    assign s_WREADY  = iRST && !w_held_q && !bvalid_q;
    assign s_ARREADY = iRST && (rstate_q == R_IDLE);
    assign s_BVALID  = bvalid_q;
    assign s_BRESP   = bresp_q;
    assign s_RVALID  = (rstate_q == R_RESP);
    assign s_RDATA   = rdata_q;
    assign s_RRESP   = rresp_q;
    assign reg_wr_pulse = pulse_q;

    always_comb begin
        aw_hs       = s_AWVALID && s_AWREADY;
        w_hs        = s_WVALID && s_WREADY;
        ar_hs       = s_ARVALID && s_ARREADY;
        wr_addr     = aw_held_q ? awaddr_q : s_AWADDR;
        wr_data     = w_held_q ? wdata_q : s_WDATA;
        wr_strb     = w_held_q ? wstrb_q : s_WSTRB;
        commit      = (aw_held_q || aw_hs) && (w_held_q || w_hs);
        wr_in_range = wr_addr < ADDR_LIMIT;
        wr_idx      = wr_addr[IDX_W+1:2];
        rd_in_range = s_ARADDR < ADDR_LIMIT;
        rd_idx      = s_ARADDR[IDX_W+1:2];
        rstate_d    = rstate_q;
        if (rstate_q == R_IDLE && ar_hs) begin
            rstate_d = R_RESP;
        end else if (rstate_q == R_RESP && s_RREADY) begin
            rstate_d = R_IDLE;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            pulse_q   <= '0;
        end else begin
            pulse_q <= '0;
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                awaddr_q  <= s_AWADDR;
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                wdata_q  <= s_WDATA;
                wstrb_q  <= s_WSTRB;
            end
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                if (wr_in_range) begin
                    pulse_q[wr_idx] <= 1'b1;
                    for (int i = 0; i < STRB_W; i++) begin
                        if (wr_strb[i]) begin
                            regs_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                        end
                    end
                end
            end else if (bvalid_q && s_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read data samples regs_q before any same-edge write lands, giving the pre-write value.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            rstate_q <= R_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rstate_q <= rstate_d;
            if (ar_hs) begin
                rdata_q <= rd_in_range ? regs_q[rd_idx] : '0;
                rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_out[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
    end
endmodule

// File: tb/tb_axi4_lite_slave.sv
// Directed bench for axi4_lite_slave: vector table of single reads/writes plus
// hand-written sequences for split AW/W, back-pressure and reset mid-transaction.
`timescale 1ns/1ps
module tb_axi4_lite_slave;
    localparam int NR = 8;

    logic         iCLK, iRST;
    logic         s_AWVALID, s_AWREADY, s_WVALID, s_WREADY, s_BVALID, s_BREADY;
    logic         s_ARVALID, s_ARREADY, s_RVALID, s_RREADY;
    logic [31:0]  s_AWADDR, s_WDATA, s_ARADDR, s_RDATA;
    logic [2:0]   s_AWPROT, s_ARPROT;
    logic [3:0]   s_WSTRB;
    logic [1:0]   s_BRESP, s_RRESP;
    logic [255:0] regs_out;
    logic [7:0]   reg_wr_pulse;

    axi4_lite_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY), .s_AWADDR(s_AWADDR), .s_AWPROT(s_AWPROT),
        .s_WVALID(s_WVALID), .s_WREADY(s_WREADY), .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB),
        .s_BVALID(s_BVALID), .s_BREADY(s_BREADY), .s_BRESP(s_BRESP),
        .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY), .s_ARADDR(s_ARADDR), .s_ARPROT(s_ARPROT),
        .s_RVALID(s_RVALID), .s_RREADY(s_RREADY), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP),
        .regs_out(regs_out), .reg_wr_pulse(reg_wr_pulse)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] val;    // read: expected RDATA; in-range write: expected register afterwards
        logic [7:0]  pulse;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_regs [NR];
    vec_t        vecs [15];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] exp_flat();
        logic [255:0] f;
        for (int k = 0; k < NR; k++) f[32*k +: 32] = exp_regs[k];
        return f;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output bit ok, output logic bv, output logic [1:0] resp,
                             output logic [7:0] pulse, output logic [7:0] pulse_after, output logic bv_after);
        bit aw_done = 0, w_done = 0, aw_go, w_go;
        @(posedge iCLK); #1;
        s_AWADDR = addr; s_WDATA = data; s_WSTRB = strb;
        s_AWVALID = 1'b1; s_WVALID = 1'b1; s_BREADY = 1'b1;
        for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
            @(negedge iCLK);
            aw_go = s_AWVALID && s_AWREADY;
            w_go  = s_WVALID && s_WREADY;
            @(posedge iCLK); #1;
            if (aw_go) begin s_AWVALID = 1'b0; aw_done = 1; end
            if (w_go)  begin s_WVALID = 1'b0;  w_done = 1; end
        end
        s_AWVALID = 1'b0; s_WVALID = 1'b0;
        ok = aw_done && w_done;
        @(negedge iCLK);
        bv = s_BVALID; resp = s_BRESP; pulse = reg_wr_pulse;
        @(negedge iCLK);
        pulse_after = reg_wr_pulse; bv_after = s_BVALID;
    endtask

    task automatic axi_read(input logic [31:0] addr, output bit ok, output logic rv,
                            output logic [31:0] rdata, output logic [1:0] resp, output logic rv_after);
        bit go;
        ok = 0;
        @(posedge iCLK); #1;
        s_ARADDR = addr; s_ARVALID = 1'b1; s_RREADY = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge iCLK);
            go = s_ARVALID && s_ARREADY;
            @(posedge iCLK); #1;
            if (go) begin s_ARVALID = 1'b0; ok = 1; end
        end
        s_ARVALID = 1'b0;
        @(negedge iCLK);
        rv = s_RVALID; rdata = s_RDATA; resp = s_RRESP;
        @(negedge iCLK);
        rv_after = s_RVALID;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          ok;
        logic        v, v_after;
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [7:0]  p, p_after;
        logic        stray;

        vecs[0]  = '{0, 32'h0000_0004, 32'h0,         4'h0, 2'b00, 32'h0000_0000, 8'h00};
        vecs[1]  = '{1, 32'h0000_0004, 32'hDEADBEEF,  4'hF, 2'b00, 32'hDEADBEEF, 8'h02};
        vecs[2]  = '{0, 32'h0000_0004, 32'h0,         4'h0, 2'b00, 32'hDEADBEEF, 8'h00};
        vecs[3]  = '{1, 32'h0000_0008, 32'hFFFFFFFF,  4'hF, 2'b00, 32'hFFFFFFFF, 8'h04};
        vecs[4]  = '{1, 32'h0000_0040, 32'h12345678,  4'hF, 2'b10, 32'h0,        8'h00};
        vecs[5]  = '{0, 32'h0000_0040, 32'h0,         4'h0, 2'b10, 32'h0000_0000, 8'h00};
        vecs[6]  = '{1, 32'h0000_001F, 32'hA5A5A5A5,  4'h0, 2'b00, 32'h0000_0000, 8'h80};
        vecs[7]  = '{1, 32'h0000_001C, 32'h11223344,  4'h8, 2'b00, 32'h1100_0000, 8'h80};
        vecs[8]  = '{0, 32'h0000_001E, 32'h0,         4'h0, 2'b00, 32'h1100_0000, 8'h00};
        vecs[9]  = '{1, 32'h0000_0020, 32'h99999999,  4'hF, 2'b10, 32'h0,        8'h00};
        vecs[10] = '{0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'h0000_0000, 8'h00};
        vecs[11] = '{0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'hFFFFFFFF, 8'h00};
        vecs[12] = '{1, 32'h0000_0001, 32'h0000ABCD,  4'h3, 2'b00, 32'h0000_ABCD, 8'h01};
        vecs[13] = '{0, 32'h0000_0003, 32'h0,         4'h0, 2'b00, 32'h0000_ABCD, 8'h00};
        vecs[14] = '{0, 32'hFFFF_FFFC, 32'h0,         4'h0, 2'b10, 32'h0000_0000, 8'h00};
        for (int k = 0; k < NR; k++) exp_regs[k] = 32'h0;

        iRST = 1'b0;
        s_AWVALID = 0; s_WVALID = 0; s_ARVALID = 0; s_BREADY = 0; s_RREADY = 0;
        s_AWADDR = 0; s_WDATA = 0; s_WSTRB = 0; s_ARADDR = 0; s_AWPROT = 3'b010; s_ARPROT = 3'b001;

        // Reset state
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        chk("rst_readys", 256'({s_AWREADY, s_WREADY, s_ARREADY}), 256'(0));
        chk("rst_valids", 256'({s_BVALID, s_RVALID, s_BRESP, s_RRESP}), 256'(0));
        chk("rst_rdata", 256'(s_RDATA), 256'(0));
        chk("rst_pulse", 256'(reg_wr_pulse), 256'(0));
        chk("rst_regs", regs_out, 256'(0));
        iRST = 1'b1;
        #1;
        chk("post_rst_readys", 256'({s_AWREADY, s_WREADY, s_ARREADY}), 256'(3'b111));

        // Vector table
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, ok, v, resp, p, p_after, v_after);
                if (vecs[i].resp == 2'b00) exp_regs[vecs[i].addr[4:2]] = vecs[i].val;
                chk($sformatf("v%0d_wr_handshake", i), 256'(ok), 256'(1));
                chk($sformatf("v%0d_bvalid", i), 256'(v), 256'(1));
                chk($sformatf("v%0d_bresp", i), 256'(resp), 256'(vecs[i].resp));
                chk($sformatf("v%0d_pulse", i), 256'(p), 256'(vecs[i].pulse));
                chk($sformatf("v%0d_pulse_clear", i), 256'(p_after), 256'(0));
                chk($sformatf("v%0d_bvalid_clear", i), 256'(v_after), 256'(0));
                chk($sformatf("v%0d_regs", i), regs_out, exp_flat());
            end else begin
                axi_read(vecs[i].addr, ok, v, rd, resp, v_after);
                chk($sformatf("v%0d_rd_handshake", i), 256'(ok), 256'(1));
                chk($sformatf("v%0d_rvalid", i), 256'(v), 256'(1));
                chk($sformatf("v%0d_rdata", i), 256'(rd), 256'(vecs[i].val));
                chk($sformatf("v%0d_rresp", i), 256'(resp), 256'(vecs[i].resp));
                chk($sformatf("v%0d_rvalid_clear", i), 256'(v_after), 256'(0));
            end
        end

        // W three cycles ahead of AW, partial strobes over FFFFFFFF
        @(posedge iCLK); #1;
        s_WDATA = 32'h12345678; s_WSTRB = 4'b0101; s_WVALID = 1'b1; s_BREADY = 1'b1;
        @(negedge iCLK);
        chk("wfirst_wready", 256'(s_WREADY), 256'(1));
        @(posedge iCLK); #1;
        s_WVALID = 1'b0;
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        chk("wfirst_wready_low", 256'(s_WREADY), 256'(0));
        chk("wfirst_no_bvalid", 256'(s_BVALID), 256'(0));
        @(posedge iCLK); #1;
        s_AWADDR = 32'h8; s_AWVALID = 1'b1;
        @(negedge iCLK);
        chk("wfirst_awready", 256'(s_AWREADY), 256'(1));
        @(posedge iCLK); #1;
        s_AWVALID = 1'b0;
        exp_regs[2] = 32'hFF34FF78;
        @(negedge iCLK);
        chk("wfirst_bvalid", 256'({s_BVALID, s_BRESP}), 256'(3'b100));
        chk("wfirst_pulse", 256'(reg_wr_pulse), 256'(8'h04));
        chk("wfirst_regs", regs_out, exp_flat());
        @(negedge iCLK);
        chk("wfirst_bvalid_clear", 256'(s_BVALID), 256'(0));

        // Back-pressure, with a read colliding with a write to the same register
        @(posedge iCLK); #1;
        s_BREADY = 1'b0; s_RREADY = 1'b0;
        s_AWADDR = 32'h4; s_WDATA = 32'h0BADF00D; s_WSTRB = 4'hF; s_ARADDR = 32'h4;
        s_AWVALID = 1'b1; s_WVALID = 1'b1; s_ARVALID = 1'b1;
        @(posedge iCLK); #1;
        s_AWVALID = 1'b0; s_WVALID = 1'b0; s_ARVALID = 1'b0;
        exp_regs[1] = 32'h0BADF00D;
        for (int c = 0; c < 4; c++) begin
            @(negedge iCLK);
            chk($sformatf("bp%0d_valids", c), 256'({s_BVALID, s_RVALID}), 256'(2'b11));
            chk($sformatf("bp%0d_resps", c), 256'({s_BRESP, s_RRESP}), 256'(0));
            chk($sformatf("bp%0d_rdata_prewrite", c), 256'(s_RDATA), 256'(32'hDEADBEEF));
            chk($sformatf("bp%0d_readys", c), 256'({s_AWREADY, s_WREADY, s_ARREADY}), 256'(0));
            chk($sformatf("bp%0d_pulse", c), 256'(reg_wr_pulse), 256'((c == 0) ? 8'h02 : 8'h00));
        end
        chk("bp_regs", regs_out, exp_flat());
        @(posedge iCLK); #1;
        s_BREADY = 1'b1; s_RREADY = 1'b1;
        @(negedge iCLK);
        chk("bp_valids_before_edge", 256'({s_BVALID, s_RVALID}), 256'(2'b11));
        @(negedge iCLK);
        chk("bp_valids_cleared", 256'({s_BVALID, s_RVALID}), 256'(0));
        chk("bp_readys_back", 256'({s_AWREADY, s_WREADY, s_ARREADY}), 256'(3'b111));
        @(negedge iCLK);
        chk("bp_single_completion", 256'({s_BVALID, s_RVALID}), 256'(0));

        // Reset with a read response pending and only AW accepted
        @(posedge iCLK); #1;
        s_RREADY = 1'b0; s_BREADY = 1'b1;
        s_ARADDR = 32'h4; s_ARVALID = 1'b1;
        s_AWADDR = 32'h10; s_AWVALID = 1'b1;
        @(posedge iCLK); #1;
        s_ARVALID = 1'b0; s_AWVALID = 1'b0;
        @(negedge iCLK);
        chk("mid_rvalid", 256'(s_RVALID), 256'(1));
        chk("mid_aw_held", 256'({s_AWREADY, s_WREADY, s_BVALID}), 256'(3'b010));
        #2 iRST = 1'b0;
        #1;
        for (int k = 0; k < NR; k++) exp_regs[k] = 32'h0;
        chk("arst_valids", 256'({s_BVALID, s_RVALID}), 256'(0));
        chk("arst_readys", 256'({s_AWREADY, s_WREADY, s_ARREADY}), 256'(0));
        chk("arst_rdata", 256'({s_RDATA, s_RRESP}), 256'(0));
        chk("arst_regs", regs_out, exp_flat());
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        iRST = 1'b1;
        s_RREADY = 1'b1;
        @(posedge iCLK); #1;
        s_WDATA = 32'h77777777; s_WSTRB = 4'hF; s_WVALID = 1'b1;
        @(negedge iCLK);
        chk("arst_wready", 256'(s_WREADY), 256'(1));
        @(posedge iCLK); #1;
        s_WVALID = 1'b0;
        stray = 1'b0;
        repeat (5) begin
            @(negedge iCLK);
            stray = stray | s_BVALID | s_RVALID | (|reg_wr_pulse);
        end
        chk("arst_no_response", 256'(stray), 256'(0));
        chk("arst_regs_after", regs_out, exp_flat());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
